// File: rtl/gate_sensor_front.sv
// gate_sensor_front: debounces the entry/exit beam sensors and issues arbitrated park/reject pulses.
// Optional per-lane blocked timeout with a sticky fault flag is enabled by defining LANE_TIMEOUT_EN.
module gate_sensor_front #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CAP        = 50
`ifdef LANE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_in,
    input  logic       sens_out,
    input  logic [5:0] count,
    output logic       park_in,
    output logic       park_out,
    output logic       reject_in,
    output logic       reject_out,
    output logic       in_busy,
    output logic       out_busy,
    output logic       fault
);

    localparam int unsigned DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BLOCKED = 2'd1,
        REQ     = 2'd2
    } lane_state_e;

    // Lane index 0 is the entry lane, 1 is the exit lane.
    logic [1:0]       sens_c;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       busy_q;
    logic [DEB_W-1:0] dcnt_q [2];
    lane_state_e      state_q [2];

    logic [1:0] grant_c;
    logic [1:0] armed_c;
    logic       full_c;
    logic       empty_c;
    logic       accept_c;

    logic park_in_q;
    logic park_out_q;
    logic reject_in_q;
    logic reject_out_q;
    logic holdoff_q;

`ifdef LANE_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q [2];
    logic [1:0]       armed_q;
    logic             fault_q;

    assign armed_c = armed_q;
    assign fault   = fault_q;
`else
    assign armed_c = 2'b11;
    assign fault   = 1'b0;
`endif

    assign sens_c   = {sens_out, sens_in};
    assign full_c   = (count >= 6'(CAP));
    assign empty_c  = (count == 6'd0);
    assign accept_c = (grant_c[0] & ~full_c) | (grant_c[1] & ~empty_c);

    // Fixed-priority arbiter; holdoff lets the counter absorb the previous pulse first.
    always_comb begin
        grant_c = 2'b00;
        if (!holdoff_q) begin
            if (state_q[0] == REQ) begin
                grant_c[0] = 1'b1;
            end else if (state_q[1] == REQ) begin
                grant_c[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            deb_q        <= 2'b00;
            busy_q       <= 2'b00;
            park_in_q    <= 1'b0;
            park_out_q   <= 1'b0;
            reject_in_q  <= 1'b0;
            reject_out_q <= 1'b0;
            holdoff_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
`ifdef LANE_TIMEOUT_EN
            armed_q <= 2'b11;
            fault_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                tmo_q[i] <= '0;
            end
`endif
        end else begin
            sync1_q <= sens_c;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                // Debounced level flips only after DEB_CYCLES consecutive differing samples.
                if (sync2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DEB_LAST) begin
                    deb_q[i]  <= ~deb_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + DEB_W'(1);
                end

`ifdef LANE_TIMEOUT_EN
                if (!deb_q[i]) begin
                    armed_q[i] <= 1'b1;
                end
`endif
                case (state_q[i])
                    IDLE: begin
                        if (deb_q[i] && armed_c[i]) begin
                            state_q[i] <= BLOCKED;
                            busy_q[i]  <= 1'b1;
`ifdef LANE_TIMEOUT_EN
                            tmo_q[i]   <= '0;
`endif
                        end
                    end
                    BLOCKED: begin
                        if (!deb_q[i]) begin
                            state_q[i] <= REQ;
                        end
`ifdef LANE_TIMEOUT_EN
                        else if (tmo_q[i] == TMO_LAST) begin
                            state_q[i] <= IDLE;
                            busy_q[i]  <= 1'b0;
                            armed_q[i] <= 1'b0;
                            fault_q    <= 1'b1;
                        end else begin
                            tmo_q[i] <= tmo_q[i] + TMO_W'(1);
                        end
`endif
                    end
                    REQ: begin
                        if (grant_c[i]) begin
                            state_q[i] <= IDLE;
                            busy_q[i]  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        busy_q[i]  <= 1'b0;
                    end
                endcase
            end

            park_in_q    <= grant_c[0] & ~full_c;
            reject_in_q  <= grant_c[0] & full_c;
            park_out_q   <= grant_c[1] & ~empty_c;
            reject_out_q <= grant_c[1] & empty_c;
            holdoff_q    <= accept_c;
        end
    end

    assign park_in    = park_in_q;
    assign park_out   = park_out_q;
    assign reject_in  = reject_in_q;
    assign reject_out = reject_out_q;
    assign in_busy    = busy_q[0];
    assign out_busy   = busy_q[1];

endmodule
